set_job_sched: RTL and testbench

Round-robin job scheduler that shares one SET candidate-counting engine between NREQ requesters. Each requester submits a job (central, radius, mode) through a valid/ready handshake into its own one-entry slot. The scheduler issues one job at a time to the engine's en/busy interface, waits for the engine's valid pulse with a watchdog, and returns the candidate tagged with the requester id. It sits between the requester fabric and the SET engine, and both share `clk` and `rst`.

---
 rtl/set_sched_pkg.sv | 18 +
 rtl/set_job_sched_rr_arbiter.sv | 41 ++++
 rtl/set_job_sched.sv | 183 ++++++++++++++++++
 tb/tb_set_job_sched.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_sched_pkg.sv
// Shared state encoding and field widths for the SET job scheduler.
package set_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam int CEN_W  = 24;
    localparam int RAD_W  = 12;
    localparam int MODE_W = 2;
    localparam int CAND_W = 8;

    localparam logic [MODE_W-1:0] MODE_INVALID = 2'd3;

endpackage

// File: rtl/set_job_sched_rr_arbiter.sv
// Combinational round-robin pick over full slots, searching from last+1.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         i_req,
    input  logic [$clog2(NREQ)-1:0] i_last,
    input  logic                    i_en,
    output logic [NREQ-1:0]         o_gnt,
    output logic [$clog2(NREQ)-1:0] o_idx
);
    localparam int IW = $clog2(NREQ);

    logic [2*NREQ-1:0] w_dbl;
    logic [2*NREQ-1:0] w_sh;
    logic [NREQ-1:0]   w_rot;
    logic [IW:0]       w_base;
    logic              w_hit;

    // Doubling the vector lets a plain shift act as a rotate, even for
    // NREQ that is not a power of two.
    assign w_base = {1'b0, i_last} + (IW+1)'(1);
    assign w_dbl  = {i_req, i_req};
    assign w_sh   = w_dbl >> w_base;
    assign w_rot  = w_sh[NREQ-1:0];

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        w_hit = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (i_en && !w_hit && w_rot[k]) begin
                w_hit = 1'b1;
                o_idx = IW'((int'(w_base) + k) % NREQ);
            end
        end
        if (w_hit) begin
            o_gnt = NREQ'(1) << o_idx;
        end
    end

endmodule

// File: rtl/set_job_sched.sv
// Shares one SET engine between NREQ requesters, one job in flight.
module set_job_sched
    import set_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*CEN_W-1:0]   req_central,
    input  logic [NREQ*RAD_W-1:0]   req_radius,
    input  logic [NREQ*MODE_W-1:0]  req_mode,
    output logic                    set_en,
    output logic [CEN_W-1:0]        set_central,
    output logic [RAD_W-1:0]        set_radius,
    output logic [MODE_W-1:0]       set_mode,
    input  logic                    set_busy,
    input  logic                    set_valid,
    input  logic [CAND_W-1:0]       set_candidate,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [CAND_W-1:0]       res_candidate,
    output logic                    res_err
);
    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    state_t r_state;
    state_t w_next;

    logic [NREQ-1:0]             r_full;
    logic [NREQ-1:0]             w_acc;
    logic [NREQ-1:0]             w_gnt;
    logic [NREQ-1:0][CEN_W-1:0]  r_cen;
    logic [NREQ-1:0][RAD_W-1:0]  r_rad;
    logic [NREQ-1:0][MODE_W-1:0] r_mode;
    logic [IW-1:0]               r_last;
    logic [IW-1:0]               w_idx;
    logic [CEN_W-1:0]            r_set_cen;
    logic [RAD_W-1:0]            r_set_rad;
    logic [MODE_W-1:0]           r_set_mode;
    logic [CW-1:0]               r_cnt;
    logic                        r_res_valid;
    logic                        r_res_err;
    logic [IW-1:0]               r_res_id;
    logic [CAND_W-1:0]           r_res_cand;
    logic                        w_set_en;
    logic                        w_done;
    logic                        w_err;
    logic [CAND_W-1:0]           w_cand;

    assign w_acc = req_valid & ~r_full;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .i_req  (r_full),
        .i_last (r_last),
        .i_en   (r_state == IDLE),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= '0;
            r_cen  <= '0;
            r_rad  <= '0;
            r_mode <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_acc[i]) begin
                    r_full[i] <= 1'b1;
                    r_cen[i]  <= req_central[i*CEN_W +: CEN_W];
                    r_rad[i]  <= req_radius[i*RAD_W +: RAD_W];
                    r_mode[i] <= req_mode[i*MODE_W +: MODE_W];
                end else if (w_gnt[i]) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    // The issue register doubles as the engine payload, so it stays
    // stable from ISSUE until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= IW'(NREQ - 1);
            r_set_cen  <= '0;
            r_set_rad  <= '0;
            r_set_mode <= '0;
        end else if (|w_gnt) begin
            r_last     <= w_idx;
            r_set_cen  <= r_cen[w_idx];
            r_set_rad  <= r_rad[w_idx];
            r_set_mode <= r_mode[w_idx];
        end
    end

    always_comb begin
        w_next   = r_state;
        w_set_en = 1'b0;
        w_done   = 1'b0;
        w_err    = 1'b0;
        w_cand   = '0;
        unique case (r_state)
            IDLE: begin
                if (|w_gnt) w_next = ISSUE;
            end
            ISSUE: begin
                if (r_set_mode == MODE_INVALID) begin
                    w_next = RESP;
                    w_done = 1'b1;
                    w_err  = 1'b1;
                end else if (!set_busy) begin
                    w_set_en = 1'b1;
                    w_next   = WAIT;
                end
            end
            WAIT: begin
                if (set_valid) begin
                    w_next = RESP;
                    w_done = 1'b1;
                    w_cand = set_candidate;
                end else if (r_cnt == CNT_LAST) begin
                    w_next = RESP;
                    w_done = 1'b1;
                    w_err  = 1'b1;
                end
            end
            RESP: begin
                if (res_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_set_en) begin
            r_cnt <= '0;
        end else if (r_state == WAIT && r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_id    <= '0;
            r_res_cand  <= '0;
            r_res_err   <= 1'b0;
        end else if (w_done) begin
            r_res_valid <= 1'b1;
            r_res_id    <= r_last;
            r_res_cand  <= w_cand;
            r_res_err   <= w_err;
        end else if (r_state == RESP && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign req_ready     = ~r_full;
    assign set_en        = w_set_en;
    assign set_central   = r_set_cen;
    assign set_radius    = r_set_rad;
    assign set_mode      = r_set_mode;
    assign res_valid     = r_res_valid;
    assign res_id        = r_res_id;
    assign res_candidate = r_res_cand;
    assign res_err       = r_res_err;

endmodule

// File: tb/tb_set_job_sched.sv
// Scoreboard bench for set_job_sched with a behavioural SET engine model.
module tb_set_job_sched;
    import set_sched_pkg::*;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 256;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*24-1:0]     req_central = '0;
    logic [NREQ*12-1:0]     req_radius = '0;
    logic [NREQ*2-1:0]      req_mode = '0;
    logic                   set_en;
    logic [23:0]            set_central;
    logic [11:0]            set_radius;
    logic [1:0]             set_mode;
    logic                   set_busy;
    logic                   set_valid;
    logic [7:0]             set_candidate;
    logic                   res_valid;
    logic                   res_ready = 1'b1;
    logic [1:0]             res_id;
    logic [7:0]             res_candidate;
    logic                   res_err;

    always #5 clk = ~clk;

    set_job_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_central   (req_central),
        .req_radius    (req_radius),
        .req_mode      (req_mode),
        .set_en        (set_en),
        .set_central   (set_central),
        .set_radius    (set_radius),
        .set_mode      (set_mode),
        .set_busy      (set_busy),
        .set_valid     (set_valid),
        .set_candidate (set_candidate),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_id        (res_id),
        .res_candidate (res_candidate),
        .res_err       (res_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: bound expired", nm);
    endtask

    // Lattice points within radius r: circle, diamond, square.
    function automatic int ref_cand(input int md, input int r);
        int n;
        n = 0;
        case (md)
            0: begin
                for (int dx = -r; dx <= r; dx++)
                    for (int dy = -r; dy <= r; dy++)
                        if (dx*dx + dy*dy <= r*r) n++;
            end
            1: n = 2*r*r + 2*r + 1;
            2: n = (2*r + 1) * (2*r + 1);
            default: n = 0;
        endcase
        if (n > 255) n = 255;
        return n;
    endfunction

    // Engine model
    logic       e_busy = 1'b1;
    logic       e_boot = 1'b1;
    logic       e_vld  = 1'b0;
    logic [7:0] e_cand = '0;
    int         e_cnt  = 0;
    int         e_lat  = 20;
    bit         e_mute = 1'b0;
    bit         e_rand = 1'b0;
    logic       inj_vld  = 1'b0;
    logic [7:0] inj_cand = '0;

    assign set_busy      = e_busy;
    assign set_valid     = e_vld | inj_vld;
    assign set_candidate = inj_vld ? inj_cand : e_cand;

    always @(posedge clk) begin
        e_vld <= 1'b0;
        if (rst) begin
            e_busy <= 1'b1;
            e_boot <= 1'b1;
            e_cnt  <= 0;
        end else if (e_boot) begin
            e_boot <= 1'b0;
            e_busy <= 1'b0;
        end else if (e_cnt > 0) begin
            e_cnt <= e_cnt - 1;
            if (e_cnt == 1) begin
                e_busy <= 1'b0;
                e_vld  <= 1'b1;
            end
        end else if (set_en) begin
            e_busy <= 1'b1;
            e_cnt  <= e_mute ? TIMEOUT + 40 :
                      (e_rand ? int'($urandom_range(3, 30)) : e_lat);
            e_cand <= 8'(ref_cand(int'(set_mode), int'(set_radius)));
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Scoreboard: expected {err, cand} per requester.
    logic [8:0] expq [NREQ][$];
    logic [8:0] mon_e;
    int         n_exp = 0;
    int         n_res = 0;
    int         en_cnt = 0;
    int         en_cyc = 0;
    int         sv_cyc = 0;
    int         rv_cyc = 0;
    logic       rv_q = 1'b0;
    int         got_ids[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (set_en) begin
                en_cnt++;
                en_cyc = cyc;
                if (set_busy) fail_now("set_en_while_busy");
            end
            if (e_vld) sv_cyc = cyc;
            if (res_valid && !rv_q) rv_cyc = cyc;
            if (res_valid && res_ready) begin
                if (expq[res_id].size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: id %0d cand %0d err %0d",
                             res_id, res_candidate, res_err);
                end else begin
                    mon_e = expq[res_id].pop_front();
                    chk($sformatf("cand_id%0d", res_id), res_candidate, mon_e[7:0]);
                    chk($sformatf("err_id%0d", res_id), res_err, mon_e[8]);
                end
                got_ids.push_back(int'(res_id));
                n_res++;
            end
        end
        rv_q = res_valid;
    end

    int acc_cyc = 0;

    task automatic load(input int id, input int cen, input int rad, input int md,
                        input bit to_exp);
        logic [8:0] e;
        req_central[id*24 +: 24] = 24'(cen);
        req_radius[id*12 +: 12]  = 12'(rad);
        req_mode[id*2 +: 2]      = 2'(md);
        req_valid[id]            = 1'b1;
        e[8]   = (md == 3) || to_exp;
        e[7:0] = e[8] ? 8'd0 : 8'(ref_cand(md, rad));
        expq[id].push_back(e);
        n_exp++;
    endtask

    task automatic submit_mask(input logic [NREQ-1:0] m, input int maxmode);
        int n;
        n = 0;
        while (((req_ready & m) != m) && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        if ((req_ready & m) != m) begin
            fail_now("ready_wait_mask");
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (m[i]) load(i, int'($urandom_range(0, 32'hFFFFFF)),
                               int'($urandom_range(0, 7)),
                               int'($urandom_range(0, maxmode)), 1'b0);
            acc_cyc = cyc;
            @(posedge clk); #1;
            req_valid = '0;
        end
    endtask

    task automatic submit_one(input int id, input int cen, input int rad,
                              input int md, input bit to_exp);
        int n;
        n = 0;
        while (!req_ready[id] && n < 5000) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready[id]) begin
            fail_now("ready_wait_one");
        end else begin
            load(id, cen, rad, md, to_exp);
            acc_cyc = cyc;
            @(posedge clk); #1;
            req_valid[id] = 1'b0;
        end
    endtask

    task automatic wait_res(input int target);
        int n;
        n = 0;
        while (n_res < target && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        if (n_res < target) fail_now("result_wait");
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 4'hF);
        chk({tag, "_set_en"}, set_en, 0);
        chk({tag, "_set_central"}, set_central, 0);
        chk({tag, "_set_radius"}, set_radius, 0);
        chk({tag, "_set_mode"}, set_mode, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_id"}, res_id, 0);
        chk({tag, "_res_cand"}, res_candidate, 0);
        chk({tag, "_res_err"}, res_err, 0);
    endtask

    int         base;
    int         en0;
    int         nb;
    int         chg;
    int         first;
    int         model_last;
    int         ord[5];
    logic [1:0] sid;
    logic [7:0] sc;
    logic       se;
    bit         rand_done;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Contention with a refill of slot 0 during job 1
        e_lat = 20;
        base = n_res;
        got_ids.delete();
        submit_mask(4'hF, 2);
        wait_res(base + 1);
        submit_one(0, 24'h123456, 5, 1, 1'b0);
        wait_res(base + 5);
        ord = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++)
            chk($sformatf("rr_order%0d", k),
                (got_ids.size() > k) ? got_ids[k] : -1, ord[k]);

        // Single job, nominal engine latency
        e_lat = 195;
        base = n_res;
        en0 = en_cnt;
        submit_one(0, {12'd4, 12'd4}, 3, 0, 1'b0);
        wait_res(base + 1);
        chk("single_en_pulses", en_cnt - en0, 1);
        chk("single_issue_lat", en_cyc - acc_cyc, 2);
        chk("single_res_lat", rv_cyc - sv_cyc, 1);

        // Invalid mode bypasses the engine
        base = n_res;
        en0 = en_cnt;
        submit_one(2, 24'hABCDEF, 4, 3, 1'b0);
        wait_res(base + 1);
        chk("m3_no_en", en_cnt - en0, 0);
        chk("m3_lat_le3", int'((rv_cyc - (acc_cyc + 1)) <= 3), 1);

        // Watchdog, then late and spurious engine strobes
        e_mute = 1'b1;
        base = n_res;
        submit_one(1, 24'h000777, 2, 0, 1'b1);
        wait_res(base + 1);
        chk("to_edges", rv_cyc - (en_cyc + 1), TIMEOUT);
        nb = 0;
        while (set_busy && nb < 400) begin
            @(posedge clk); #1; nb++;
        end
        if (set_busy) fail_now("late_valid_wait");
        e_mute = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        inj_cand = 8'd77;
        inj_vld = 1'b1;
        @(posedge clk); #1;
        inj_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stale_ignored", n_res, base + 1);
        e_lat = 12;
        submit_one(3, 24'h00F00F, 6, 2, 1'b0);
        wait_res(base + 2);
        model_last = 3;

        // Backpressure with every slot full
        res_ready = 1'b0;
        base = n_res;
        got_ids.delete();
        first = (model_last + 1) % NREQ;
        submit_mask(4'hF, 2);
        nb = 0;
        while (!res_valid && nb < 200) begin
            @(posedge clk); #1; nb++;
        end
        if (!res_valid) fail_now("bp_res_wait");
        sid = res_id;
        sc = res_candidate;
        se = res_err;
        en0 = en_cnt;
        chg = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (!res_valid || res_id !== sid || res_candidate !== sc ||
                res_err !== se) chg++;
        end
        chk("bp_stable", chg, 0);
        chk("bp_no_en", en_cnt - en0, 0);
        chk("bp_id", sid, first);
        chk("bp_req_ready", req_ready, 1 << first);
        res_ready = 1'b1;
        wait_res(base + 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("bp_order%0d", k),
                (got_ids.size() > k) ? got_ids[k] : -1, (first + k) % NREQ);

        // Reset while the engine is working
        e_lat = 150;
        en0 = en_cnt;
        submit_one(1, 24'h0A0A0A, 7, 0, 1'b0);
        nb = 0;
        while (en_cnt == en0 && nb < 100) begin
            @(posedge clk); #1; nb++;
        end
        if (en_cnt == en0) fail_now("rstw_en_wait");
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_vals("rstw");
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) expq[i].delete();
        n_exp = n_res;
        e_lat = 40;
        base = n_res;
        submit_one(0, {12'd4, 12'd4}, 3, 0, 1'b0);
        wait_res(base + 1);

        // Randomized traffic with random consumer stalls
        e_rand = 1'b1;
        rand_done = 1'b0;
        fork
            begin
                repeat (40)
                    submit_one(int'($urandom_range(0, NREQ - 1)),
                               int'($urandom_range(0, 32'hFFFFFF)),
                               int'($urandom_range(0, 7)),
                               int'($urandom_range(0, 3)), 1'b0);
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    res_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        res_ready = 1'b1;
        wait_res(n_exp);

        nb = 0;
        for (int i = 0; i < NREQ; i++) nb += expq[i].size();
        chk("sb_drained", nb, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
